digit_serial_addsub: RTL and testbench
======================================

# digit_serial_addsub

Parametrised multi-cycle adder/subtractor for the ALU datapath, successor to the fixed 8-bit ripple-carry adder. Operands are latched on a start handshake and processed DIGIT bits per clock through one small ripple-carry digit adder, trading latency for area at wide WIDTH. The block produces sum, carry-out, signed overflow and zero flags with a one-cycle done pulse. It sits between the ALU operand registers and the result mux.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH evenly. N = WIDTH/DIGIT digit cycles.
- clk  in  1  rising-edge clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on a clock edge where ready=1.
- sub  in  1  0: S = A + B + Cin; 1: S = A − B − Cin.
- A  in  WIDTH  operand A (unsigned or two's complement).
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (sub=0) or borrow-in (sub=1).
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; results valid.
- S  out  WIDTH  result.
- Cout  out  1  carry out of the MSB. For sub=1 this is NOT-borrow: 1 means no borrow.
- V  out  1  signed overflow.
- Z  out  1  high when S == 0.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after the Nth digit edge.
  - DONE → IDLE unconditionally on the next edge.
- Accept, on the edge with start & ready:
  - Latch A into opA.
  - Latch B ^ {WIDTH{sub}} into opB.
  - Set carry = Cin ^ sub, so subtract computes A + ~B + ~Cin.
  - Clear the digit counter to 0.
- Each RUN edge:
  - digit[i] = opA[i·DIGIT +: DIGIT] + opB[i·DIGIT +: DIGIT] + carry.
  - Write the DIGIT-bit sum into the result register slice i.
  - carry ← carry-out of the digit adder.
  - Increment i.
- Flag update on the final RUN edge:
  - Cout ← final carry.
  - V ← (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]), using the inverted B.
  - Z ← (full result == 0).
- S, Cout, V and Z change only on the final RUN edge. They hold their values through DONE and IDLE until the next operation's final edge.
- start is ignored in RUN and DONE; there is no queueing. A, B, Cin and sub are don't-care after acceptance.
- Reset values: state = IDLE, ready = 1, done = 0, S = 0, Cout = 0, V = 0, Z = 0, counter = 0, carry = 0.
- Reset during RUN or DONE aborts the operation. No done is produced, and all outputs take their reset values on that edge.
- DIGIT = WIDTH (N = 1) is legal: a single RUN cycle.

## Timing
- Start is accepted at edge t0. RUN edges are t1..tN.
- done is high for exactly the cycle following edge tN, i.e. while in DONE.
- ready is low from t0 until the edge that leaves DONE. The next start can therefore be accepted at edge tN+2 at the earliest.
- Throughput: one operation per N+2 cycles.
- Result latency: N+1 cycles from the accepting edge to the done cycle.
- All outputs are registered except ready, which is decoded from state.
- Combinational path per cycle: one DIGIT-bit ripple plus the mux. This path is what DIGIT trades against.

## Structure
- Shared include alu_defs.vh holds:
  - the state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the ALU mode constants (ADD = 1'b0, SUB = 1'b1), also used by the ALU top.
- Sub-module rca_digit: a combinational DIGIT-bit ripple-carry adder with ports a, b, ci, s, co, built from a generate loop of full adders.
- The top holds the FSM, operand/result shift registers or indexed slices, the counter and the flag logic.
- A parameter check flags WIDTH % DIGIT != 0 at elaboration.

## Test plan
All cases use WIDTH = 8, DIGIT = 4 (N = 2) unless stated.
- Add 0x12 + 0x34, Cin = 0 → S = 0x46, Cout = 0, V = 0, Z = 0. done pulses exactly 3 cycles after the accepting edge, and ready returns 1 one cycle later.
- Add 0x55 + 0xAA, Cin = 1 → S = 0x00, Cout = 1, V = 0, Z = 1.
- Add 0x72 + 0x27, Cin = 0 → S = 0x99, Cout = 0, V = 1.
- Subtract:
  - 0x72 − 0x27, Cin = 0 → S = 0x4B, Cout = 1, V = 0.
  - 0x80 − 0x08, Cin = 0 → S = 0x78, Cout = 1, V = 1.
  - 0x08 − 0x80, Cin = 1 → S = 0x87, Cout = 0, V = 1.
- Handshake and reset:
  - Hold start high continuously with changing operands: only IDLE-cycle starts are accepted, and results match the latched operands.
  - Assert reset on the first RUN cycle: no done, outputs go to 0, ready = 1 the next cycle.
- Parameter sweep, exhaustive random against the behavioural A ± B ± Cin model:
  - DIGIT = 8 instance: done one cycle earlier than N = 2.
  - WIDTH = 16, DIGIT = 2 (N = 8): 0xFFFF + 0x0001 → S = 0x0000, Cout = 1, Z = 1, done at 9 cycles.

Source files
------------

// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor and the ALU top.
//   state_t           : sequencer states (IDLE, RUN, DONE)
//   MODE_ADD/MODE_SUB : ALU add/subtract mode encodings on the 'sub' input
//   digit_count       : number of digit cycles for a WIDTH/DIGIT pair
//   count_bits        : width of a counter that indexes n digits (min 1)
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int digit_count(int width, int digit);
    return width / digit;
  endfunction

  function automatic int count_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_addsub_rca.sv
// rca_digit: combinational DIGIT-bit ripple-carry adder.
//   a, b : DIGIT-bit addends
//   ci   : carry in
//   s    : DIGIT-bit sum
//   co   : carry out of the top bit
module rca_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Each full adder owns its carry signal; stage g reads the carry of stage g-1.
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    logic w_ci;
    logic w_co;
    if (g == 0) begin : g_first
      assign w_ci = ci;
    end else begin : g_rest
      assign w_ci = g_fa[g-1].w_co;
    end
    assign s[g] = a[g] ^ b[g] ^ w_ci;
    assign w_co = (a[g] & b[g]) | (w_ci & (a[g] ^ b[g]));
  end

  assign co = g_fa[DIGIT-1].w_co;

endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle adder/subtractor, DIGIT bits per clock.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request, accepted on an edge where ready = 1
//   sub        : 0 -> S = A + B + Cin, 1 -> S = A - B - Cin
//   A, B, Cin  : operands and carry/borrow in, latched on acceptance
//   ready      : high in IDLE only (decoded from state)
//   done       : one-cycle pulse, results valid
//   S, Cout    : result and carry out (NOT-borrow when subtracting)
//   V, Z       : signed overflow and zero flags
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = count_bits(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
    $error("digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_S;
  logic             r_Cout;
  logic             r_V;
  logic             r_Z;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic [DIGIT-1:0] w_dig_s;
  logic             w_dig_co;
  logic [WIDTH-1:0] w_full;

  assign ready    = (r_state == IDLE);
  assign w_accept = start && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  assign w_dig_a = r_opA[r_cnt*DIGIT +: DIGIT];
  assign w_dig_b = r_opB[r_cnt*DIGIT +: DIGIT];

  rca_digit #(.DIGIT(DIGIT)) u_rca (
    .a  (w_dig_a),
    .b  (w_dig_b),
    .ci (r_carry),
    .s  (w_dig_s),
    .co (w_dig_co)
  );

  // Result including the digit being produced this cycle; on the final
  // edge this is the complete sum used for S and the flags.
  always_comb begin
    w_full = r_acc;
    w_full[r_cnt*DIGIT +: DIGIT] = w_dig_s;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_S     <= '0;
      r_Cout  <= 1'b0;
      r_V     <= 1'b0;
      r_Z     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        // Subtract runs as A + ~B + ~Cin, so Cout reads as NOT-borrow.
        r_opA <= A;
        unique case (sub)
          MODE_ADD: begin
            r_opB   <= B;
            r_carry <= Cin;
          end
          MODE_SUB: begin
            r_opB   <= ~B;
            r_carry <= ~Cin;
          end
          default: begin
            r_opB   <= B;
            r_carry <= Cin;
          end
        endcase
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc   <= w_full;
        r_carry <= w_dig_co;
        if (w_last) begin
          r_cnt  <= '0;
          r_S    <= w_full;
          r_Cout <= w_dig_co;
          r_V    <= (r_opA[WIDTH-1] == r_opB[WIDTH-1]) &&
                    (w_full[WIDTH-1] != r_opA[WIDTH-1]);
          r_Z    <= (w_full == '0);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign done = r_done;
  assign S    = r_S;
  assign Cout = r_Cout;
  assign V    = r_V;
  assign Z    = r_Z;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Testbench for digit_serial_addsub: three instances (8/4, 8/8, 16/2)
// checked against an integer-arithmetic model of A +/- B +/- Cin.
module tb_digit_serial_addsub;

  typedef struct packed {
    logic        rdy;
    logic        dn;
    logic [15:0] s;
    logic        co;
    logic        v;
    logic        z;
  } obs_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        v;
    logic        z;
  } res_t;

  int tests  = 0;
  int failed = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic st0, sb0, c0, rdy0, dn0, co0, v0, z0;
  logic [7:0] a0, b0, s0;
  logic st1, sb1, c1, rdy1, dn1, co1, v1, z1;
  logic [7:0] a1, b1, s1;
  logic st2, sb2, c2, rdy2, dn2, co2, v2, z2;
  logic [15:0] a2, b2, s2;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut (
    .clk(clk), .reset(reset), .start(st0), .sub(sb0), .A(a0), .B(b0), .Cin(c0),
    .ready(rdy0), .done(dn0), .S(s0), .Cout(co0), .V(v0), .Z(z0));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .reset(reset), .start(st1), .sub(sb1), .A(a1), .B(b1), .Cin(c1),
    .ready(rdy1), .done(dn1), .S(s1), .Cout(co1), .V(v1), .Z(z1));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clk(clk), .reset(reset), .start(st2), .sub(sb2), .A(a2), .B(b2), .Cin(c2),
    .ready(rdy2), .done(dn2), .S(s2), .Cout(co2), .V(v2), .Z(z2));

  function automatic int wid(int inst);
    return (inst == 2) ? 16 : 8;
  endfunction

  // done is expected in the (N+1)th cycle after the accepting edge
  function automatic int exp_lat(int inst);
    case (inst)
      0:       return 3;
      1:       return 2;
      default: return 9;
    endcase
  endfunction

  function automatic res_t model(int w, int x, int y, bit c, bit sb);
    res_t r;
    int m, half, ux, uy, sx, sy, ci, u, sr;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    ux   = x & m;
    uy   = y & m;
    sx   = (ux >= half) ? ux - (1 << w) : ux;
    sy   = (uy >= half) ? uy - (1 << w) : uy;
    ci   = c ? 1 : 0;
    if (sb) begin
      u    = ux - uy - ci;
      sr   = sx - sy - ci;
      r.co = (u >= 0);
    end else begin
      u    = ux + uy + ci;
      sr   = sx + sy + ci;
      r.co = (u > m);
    end
    r.s = 16'(u & m);
    r.v = (sr < -half) || (sr > half - 1);
    r.z = ((u & m) == 0);
    return r;
  endfunction

  function automatic obs_t sample(int inst);
    obs_t o;
    case (inst)
      0: begin o.rdy = rdy0; o.dn = dn0; o.s = 16'(s0); o.co = co0; o.v = v0; o.z = z0; end
      1: begin o.rdy = rdy1; o.dn = dn1; o.s = 16'(s1); o.co = co1; o.v = v1; o.z = z1; end
      default: begin o.rdy = rdy2; o.dn = dn2; o.s = s2; o.co = co2; o.v = v2; o.z = z2; end
    endcase
    return o;
  endfunction

  task automatic drive(int inst, bit st, bit sb, int x, int y, bit c);
    case (inst)
      0: begin st0 = st; sb0 = sb; a0 = 8'(x); b0 = 8'(y); c0 = c; end
      1: begin st1 = st; sb1 = sb; a1 = 8'(x); b1 = 8'(y); c1 = c; end
      default: begin st2 = st; sb2 = sb; a2 = 16'(x); b2 = 16'(y); c2 = c; end
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(string tag, obs_t o, res_t e);
    chk({tag, "_S"},    32'(o.s), 32'(e.s));
    chk({tag, "_Cout"}, 32'(o.co), 32'(e.co));
    chk({tag, "_V"},    32'(o.v), 32'(e.v));
    chk({tag, "_Z"},    32'(o.z), 32'(e.z));
  endtask

  // One complete operation with timing, hold and result checks.
  task automatic op(int inst, bit sb, int x, int y, bit c);
    res_t e;
    obs_t o, prev;
    int   lat;
    bit   got;
    e = model(wid(inst), x, y, c, sb);
    @(negedge clk);
    prev = sample(inst);
    chk("ready_idle", 32'(prev.rdy), 1);
    drive(inst, 1'b1, sb, x, y, c);
    @(posedge clk);
    #1;
    drive(inst, 1'b0, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      o = sample(inst);
      if (o.dn) got = 1'b1;
      else begin
        chk("S_hold_run", 32'(o.s), 32'(prev.s));
        chk("ready_busy", 32'(o.rdy), 0);
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("latency", 32'(lat), 32'(exp_lat(inst)));
    chk_res("res", o, e);
    chk("ready_in_done", 32'(o.rdy), 0);
    @(negedge clk);
    o = sample(inst);
    chk("done_one_cycle", 32'(o.dn), 0);
    chk("ready_back", 32'(o.rdy), 1);
    chk("S_hold_idle", 32'(o.s), 32'(e.s));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    res_t e;
    res_t q[$];
    int   ndone;
    int   x, y;
    bit   sb, c;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = sample(i);
      chk("rst_ready", 32'(o.rdy), 1);
      chk("rst_done", 32'(o.dn), 0);
      chk("rst_S", 32'(o.s), 0);
      chk("rst_flags", {29'd0, o.co, o.v, o.z}, 0);
    end
    reset = 1'b0;

    // Directed vectors, WIDTH=8 DIGIT=4
    op(0, 0, 'h12, 'h34, 0);
    op(0, 0, 'h55, 'hAA, 1);
    op(0, 0, 'h72, 'h27, 0);
    op(0, 1, 'h72, 'h27, 0);
    op(0, 1, 'h80, 'h08, 0);
    op(0, 1, 'h08, 'h80, 1);

    // Hold start high with changing operands; only IDLE-cycle starts count.
    ndone = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      o = sample(0);
      if (o.dn) begin
        ndone++;
        if (q.size() == 0) chk("hold_spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk_res("hold", o, e);
        end
      end
      x  = int'($urandom);
      y  = int'($urandom);
      sb = 1'($urandom);
      c  = 1'($urandom);
      drive(0, 1'b1, sb, x, y, c);
      if (o.rdy) q.push_back(model(8, x, y, c, sb));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("hold_done_count", 32'(ndone), 6);
    chk("hold_queue_empty", 32'(q.size()), 0);
    repeat (4) @(negedge clk);

    // Reset on the first RUN cycle aborts the operation.
    op(0, 0, 'h72, 'h27, 0);
    @(negedge clk);
    drive(0, 1'b1, 0, 'h33, 'h44, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    o = sample(0);
    chk("abort_ready", 32'(o.rdy), 1);
    chk("abort_done", 32'(o.dn), 0);
    chk("abort_S", 32'(o.s), 0);
    chk("abort_flags", {29'd0, o.co, o.v, o.z}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o = sample(0);
      chk("abort_no_done", 32'(o.dn), 0);
    end

    // Randomized sweeps on all three parameterisations
    for (int k = 0; k < 40; k++)
      op(0, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom));
    for (int k = 0; k < 25; k++)
      op(1, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom));
    op(2, 0, 'hFFFF, 'h0001, 0);
    for (int k = 0; k < 20; k++)
      op(2, 1'($urandom), int'($urandom), int'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
